// File: rtl/debug_sequencer_pkg.sv
// Shared debug definitions: FSM state encoding, command bytes and small helpers.
package debug_sequencer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CMD_CONT_DEF = 8'h63;
    localparam logic [BYTE_W-1:0] CMD_STEP_DEF = 8'h73;
    localparam logic [BYTE_W-1:0] CMD_NEXT_DEF = 8'h6E;
    localparam logic [BYTE_W-1:0] CMD_EXIT_DEF = 8'h65;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONT      = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_STEP_RUN  = 3'd3,
        ST_SEND_LOAD = 3'd4,
        ST_SEND_WAIT = 3'd5,
        ST_DONE      = 3'd6
    } dbg_state_e;

    // Mode indicator bundle, exactly one bit high at any time
    typedef struct packed {
        logic idle;
        logic step;
        logic send;
        logic cont;
    } led_t;

    // Register index width; a single-word dump still gets a one-bit address
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Byte lane sent for a given byte position within a word, MSB first
    function automatic logic [1:0] lane_of(input logic [1:0] byte_cnt);
        return 2'(2'd3 - byte_cnt);
    endfunction

endpackage

// File: rtl/debug_sequencer_if.sv
// UART / pipeline / register-file signals seen by the debug sequencer.
interface debug_sequencer_if
    import debug_sequencer_pkg::*;
#(
    parameter int unsigned AW = 5
);
    logic [BYTE_W-1:0] rxData;
    logic              rxDone;
    logic              haltIn;
    logic [DATA_W-1:0] regData;
    logic              txDone;
    logic              pipeEnable;
    logic [AW-1:0]     regAddr;
    logic [BYTE_W-1:0] txData;
    logic              txStart;
    logic              ledIdle;
    logic              ledStep;
    logic              ledSend;
    logic              ledCont;
    logic [BYTE_W-1:0] sendCounter;
    logic              sentFlag;

    // Environment side: UART, pipeline and register file
    modport master (
        output rxData, rxDone, haltIn, regData, txDone,
        input  pipeEnable, regAddr, txData, txStart,
        input  ledIdle, ledStep, ledSend, ledCont, sendCounter, sentFlag
    );

    // Sequencer side
    modport slave (
        input  rxData, rxDone, haltIn, regData, txDone,
        output pipeEnable, regAddr, txData, txStart,
        output ledIdle, ledStep, ledSend, ledCont, sendCounter, sentFlag
    );

endinterface

// File: rtl/debug_dump_engine.sv
// Serialises NUM_WORDS 32-bit registers to the UART, MSB byte first.
module debug_dump_engine
    import debug_sequencer_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 32,
    parameter int unsigned AW        = 5
) (
    input  logic              clock,
    input  logic              resetGral,
    input  logic              load,
    input  logic              waiting,
    input  logic              clear,
    input  logic              tx_done,
    input  logic [DATA_W-1:0] reg_data,
    output logic [AW-1:0]     reg_addr_c,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_start,
    output logic [BYTE_W-1:0] send_counter,
    output logic              byte_ack_c,
    output logic              done_c
);

    logic [AW-1:0]     word_idx;
    logic [1:0]        byte_cnt;
    logic [BYTE_W-1:0] lane_byte_c;
    logic              last_word_c;

    // Byte selection, completion detection and address exposure
    always_comb begin
        lane_byte_c = BYTE_W'(reg_data >> {lane_of(byte_cnt), 3'b000});
        last_word_c = (word_idx == AW'(NUM_WORDS - 1));
        byte_ack_c  = waiting & tx_done;
        done_c      = byte_ack_c & last_word_c & (byte_cnt == 2'd3);
        reg_addr_c  = (load | waiting) ? word_idx : '0;
    end

    // Byte latch, start pulse, indices and cumulative byte count
    always_ff @(posedge clock or negedge resetGral) begin
        if (!resetGral) begin
            word_idx     <= '0;
            byte_cnt     <= '0;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            send_counter <= '0;
        end else begin
            tx_start <= load;
            if (load) begin
                tx_data <= lane_byte_c;
            end
            if (clear) begin
                word_idx <= '0;
                byte_cnt <= '0;
            end else if (byte_ack_c) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3 && !last_word_c) begin
                    word_idx <= word_idx + AW'(1);
                end
            end
            if (byte_ack_c) begin
                send_counter <= send_counter + 8'd1;
            end
        end
    end

endmodule

// File: rtl/debug_sequencer.sv
// Debug run-control: continuous/step execution and register dump over UART.
module debug_sequencer
    import debug_sequencer_pkg::*;
#(
    parameter int unsigned       NUM_WORDS = 32,
    parameter logic [BYTE_W-1:0] CMD_CONT  = CMD_CONT_DEF,
    parameter logic [BYTE_W-1:0] CMD_STEP  = CMD_STEP_DEF,
    parameter logic [BYTE_W-1:0] CMD_NEXT  = CMD_NEXT_DEF,
    parameter logic [BYTE_W-1:0] CMD_EXIT  = CMD_EXIT_DEF
) (
    input  logic             clock,
    input  logic             resetGral,
    debug_sequencer_if.slave bus
);

    localparam int unsigned AW = addr_width(NUM_WORDS);

    dbg_state_e        state;
    dbg_state_e        next_state;
    logic              from_cont;
    logic              next_from_cont;
    logic              pipe_en;
    led_t              leds;
    logic              send_load;
    logic              send_wait;
    logic              dump_clear;
    logic              byte_ack;
    logic              dump_last;
    logic [AW-1:0]     reg_addr;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_start;
    logic [BYTE_W-1:0] send_counter;

    // State and dump-origin registers
    always_ff @(posedge clock or negedge resetGral) begin
        if (!resetGral) begin
            state     <= ST_IDLE;
            from_cont <= 1'b0;
        end else begin
            state     <= next_state;
            from_cont <= next_from_cont;
        end
    end

    // Next-state: command decode, halt detection and dump sequencing
    always_comb begin
        next_state     = state;
        next_from_cont = from_cont;
        unique case (state)
            ST_IDLE: begin
                if (bus.rxDone) begin
                    if (bus.rxData == CMD_CONT) begin
                        next_state = ST_CONT;
                    end else if (bus.rxData == CMD_STEP) begin
                        next_state = ST_STEP_WAIT;
                    end
                end
            end
            ST_CONT: begin
                if (bus.haltIn) begin
                    next_state     = ST_SEND_LOAD;
                    next_from_cont = 1'b1;
                end
            end
            ST_STEP_WAIT: begin
                if (bus.rxDone) begin
                    if (bus.rxData == CMD_NEXT) begin
                        next_state = ST_STEP_RUN;
                    end else if (bus.rxData == CMD_EXIT) begin
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_STEP_RUN: begin
                next_state     = ST_SEND_LOAD;
                next_from_cont = 1'b0;
            end
            ST_SEND_LOAD: begin
                next_state = ST_SEND_WAIT;
            end
            ST_SEND_WAIT: begin
                if (dump_last) begin
                    next_state = ST_DONE;
                end else if (byte_ack) begin
                    next_state = ST_SEND_LOAD;
                end
            end
            ST_DONE: begin
                next_state     = (from_cont || bus.haltIn) ? ST_IDLE : ST_STEP_WAIT;
                next_from_cont = 1'b0;
            end
            default: begin
                next_state     = ST_IDLE;
                next_from_cont = 1'b0;
            end
        endcase
    end

    // Outputs: pipeline enable, mode LEDs and dump-engine controls
    always_comb begin
        pipe_en    = 1'b0;
        leds       = '0;
        send_load  = 1'b0;
        send_wait  = 1'b0;
        dump_clear = 1'b0;
        unique case (state)
            ST_IDLE: begin
                leds.idle = 1'b1;
            end
            ST_CONT: begin
                leds.cont = 1'b1;
                pipe_en   = !bus.haltIn;
            end
            ST_STEP_WAIT: begin
                leds.step = 1'b1;
            end
            ST_STEP_RUN: begin
                leds.step = 1'b1;
                pipe_en   = 1'b1;
            end
            ST_SEND_LOAD: begin
                leds.send = 1'b1;
                send_load = 1'b1;
            end
            ST_SEND_WAIT: begin
                leds.send = 1'b1;
                send_wait = 1'b1;
            end
            ST_DONE: begin
                leds.send  = 1'b1;
                dump_clear = 1'b1;
            end
            default: begin
                leds.idle = 1'b1;
            end
        endcase
    end

    debug_dump_engine #(
        .NUM_WORDS (NUM_WORDS),
        .AW        (AW)
    ) u_dump (
        .clock        (clock),
        .resetGral    (resetGral),
        .load         (send_load),
        .waiting      (send_wait),
        .clear        (dump_clear),
        .tx_done      (bus.txDone),
        .reg_data     (bus.regData),
        .reg_addr_c   (reg_addr),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .send_counter (send_counter),
        .byte_ack_c   (byte_ack),
        .done_c       (dump_last)
    );

    assign bus.pipeEnable  = pipe_en;
    assign bus.regAddr     = reg_addr;
    assign bus.txData      = tx_data;
    assign bus.txStart     = tx_start;
    assign bus.ledIdle     = leds.idle;
    assign bus.ledStep     = leds.step;
    assign bus.ledSend     = leds.send;
    assign bus.ledCont     = leds.cont;
    assign bus.sendCounter = send_counter;
    assign bus.sentFlag    = dump_clear;

endmodule

// File: tb/tb_debug_sequencer.sv
// Randomised scoreboard bench for debug_sequencer.
module tb_debug_sequencer;
    import debug_sequencer_pkg::*;

    localparam int unsigned NW         = 32;
    localparam int unsigned AW         = 5;
    localparam int          DUMP_BYTES = 4 * NW;
    localparam logic [3:0]  M_IDLE     = 4'b1000;
    localparam logic [3:0]  M_STEP     = 4'b0100;
    localparam logic [3:0]  M_SEND     = 4'b0010;
    localparam logic [3:0]  M_CONT     = 4'b0001;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } exp_t;

    logic          clock;
    logic          resetGral;
    logic [31:0]   mem [NW];
    logic          tx_done_resp;
    logic          tx_done_spur;
    exp_t          exp_q [$];
    int            checks;
    int            errors;
    int            tx_total;
    int            sent_total;
    int            pe_total;
    int            exp_cnt;

    debug_sequencer_if #(.AW(AW)) ifc ();

    debug_sequencer #(.NUM_WORDS(NW)) dut (
        .clock     (clock),
        .resetGral (resetGral),
        .bus       (ifc)
    );

    // Register file model and UART transmitter completion
    assign ifc.regData = mem[ifc.regAddr];
    assign ifc.txDone  = tx_done_resp | tx_done_spur;

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] mode_now();
        return {ifc.ledIdle, ifc.ledStep, ifc.ledSend, ifc.ledCont};
    endfunction

    // UART TX model: acknowledge each started byte after 1-4 cycles
    initial begin
        int unsigned lat;
        tx_done_resp = 1'b0;
        forever begin
            @(negedge clock);
            if (ifc.txStart === 1'b1) begin
                lat = $urandom_range(1, 4);
                repeat (lat) @(posedge clock);
                #1 tx_done_resp = 1'b1;
                @(posedge clock);
                #1 tx_done_resp = 1'b0;
            end
        end
    end

    // Monitor: pop expected bytes on each txStart, count events, check LEDs
    initial begin
        exp_t e;
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clock);
            if (ifc.txStart === 1'b1) begin
                tx_total++;
                chk("txstart_width", 32'(prev_start), 32'(0));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", ifc.txData);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", 32'(ifc.txData), 32'(e.data));
                    chk("reg_addr", 32'(ifc.regAddr), 32'(e.addr));
                end
            end
            prev_start = ifc.txStart;
            if (ifc.sentFlag === 1'b1) sent_total++;
            if (ifc.pipeEnable === 1'b1) pe_total++;
            chk("led_onehot", 32'($countones(mode_now())), 32'(1));
        end
    end

    task automatic fill_mem(input bit deadbeef);
        for (int w = 0; w < int'(NW); w++) mem[w] = $urandom;
        if (deadbeef) mem[0] = 32'hDEADBEEF;
    endtask

    // Expected byte stream of one dump, derived from register contents
    task automatic push_dump();
        exp_t e;
        for (int k = 0; k < DUMP_BYTES; k++) begin
            e.addr = AW'(k / 4);
            e.data = 8'(mem[k / 4] >> (8 * (3 - (k % 4))));
            exp_q.push_back(e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock);
        #1;
        ifc.rxData = b;
        ifc.rxDone = 1'b1;
        @(posedge clock);
        #1;
        ifc.rxDone = 1'b0;
    endtask

    task automatic wait_sent(input int base);
        int n;
        n = 0;
        while (sent_total == base && n < 3000) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (sent_total == base) begin
            checks++;
            errors++;
            $display("FAIL dump_timeout actual=no_sentFlag required=sentFlag");
        end
    endtask

    // One complete dump in continuous or step mode, with a stray command mid-dump
    task automatic run_dump(input bit cont, input int delay, input bit halt_on_step, input bit deadbeef);
        int         pe0;
        int         tx0;
        int         sent0;
        int         exp_pe;
        logic [3:0] end_mode;
        logic [7:0] stray;
        fill_mem(deadbeef);
        push_dump();
        tx0   = tx_total;
        sent0 = sent_total;
        if (cont) begin
            send_byte(CMD_CONT_DEF);
            chk("mode_cont", 32'(mode_now()), 32'(M_CONT));
            pe0 = pe_total;
            repeat (delay) @(posedge clock);
            #1;
            ifc.haltIn = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                ifc.rxData = CMD_EXIT_DEF;
                ifc.rxDone = 1'b1;
            end
            @(posedge clock);
            #1;
            ifc.rxDone = 1'b0;
            chk("mode_send", 32'(mode_now()), 32'(M_SEND));
            end_mode = M_IDLE;
            exp_pe   = delay;
        end else begin
            send_byte(CMD_STEP_DEF);
            chk("mode_step", 32'(mode_now()), 32'(M_STEP));
            pe0 = pe_total;
            repeat (delay) @(posedge clock);
            send_byte(CMD_NEXT_DEF);
            if (halt_on_step) ifc.haltIn = 1'b1;
            end_mode = halt_on_step ? M_IDLE : M_STEP;
            exp_pe   = 1;
        end
        repeat (20) @(posedge clock);
        case ($urandom_range(0, 3))
            0:       stray = CMD_CONT_DEF;
            1:       stray = CMD_STEP_DEF;
            2:       stray = CMD_NEXT_DEF;
            default: stray = CMD_EXIT_DEF;
        endcase
        send_byte(stray);
        wait_sent(sent0);
        @(posedge clock);
        #1;
        ifc.haltIn = 1'b0;
        exp_cnt = (exp_cnt + DUMP_BYTES) % 256;
        chk("mode_after_dump", 32'(mode_now()), 32'(end_mode));
        chk("pipe_cycles", 32'(pe_total - pe0), 32'(exp_pe));
        chk("bytes_per_dump", 32'(tx_total - tx0), 32'(DUMP_BYTES));
        chk("sent_pulses", 32'(sent_total - sent0), 32'(1));
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        chk("send_counter", 32'(ifc.sendCounter), 32'(exp_cnt));
        chk("reg_addr_idle", 32'(ifc.regAddr), 32'(0));
        if (end_mode == M_STEP) begin
            send_byte(CMD_EXIT_DEF);
            chk("mode_exit", 32'(mode_now()), 32'(M_IDLE));
        end
    endtask

    // Main stimulus
    initial begin
        int  tx0;
        int  sent0;
        int  n;
        bit  hit;
        checks       = 0;
        errors       = 0;
        tx_total     = 0;
        sent_total   = 0;
        pe_total     = 0;
        exp_cnt      = 0;
        tx_done_spur = 1'b0;
        ifc.rxData   = 8'h00;
        ifc.rxDone   = 1'b0;
        ifc.haltIn   = 1'b0;
        resetGral    = 1'b0;
        for (int w = 0; w < int'(NW); w++) mem[w] = 32'h0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_mode", 32'(mode_now()), 32'(M_IDLE));
        chk("reset_pipe", 32'(ifc.pipeEnable), 32'(0));
        chk("reset_txstart", 32'(ifc.txStart), 32'(0));
        chk("reset_txdata", 32'(ifc.txData), 32'(0));
        chk("reset_regaddr", 32'(ifc.regAddr), 32'(0));
        chk("reset_counter", 32'(ifc.sendCounter), 32'(0));
        chk("reset_sentflag", 32'(ifc.sentFlag), 32'(0));
        resetGral = 1'b1;

        // Non-start bytes and a stray txDone in IDLE do nothing
        send_byte(CMD_NEXT_DEF);
        send_byte(8'h41);
        chk("idle_ignore_mode", 32'(mode_now()), 32'(M_IDLE));
        chk("idle_ignore_pipe", 32'(pe_total), 32'(0));
        @(posedge clock);
        #1 tx_done_spur = 1'b1;
        @(posedge clock);
        #1 tx_done_spur = 1'b0;
        chk("idle_txdone_counter", 32'(ifc.sendCounter), 32'(0));

        run_dump(1'b1, 10, 1'b0, 1'b1);
        run_dump(1'b0, 5, 1'b0, 1'b0);
        run_dump(1'b1, int'($urandom_range(1, 20)), 1'b0, 1'b0);
        chk("counter_wrap_384", 32'(ifc.sendCounter), 32'(128));

        for (int i = 0; i < 3; i++) begin
            run_dump(1'($urandom_range(0, 1)), int'($urandom_range(1, 20)),
                     1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset while byte 50 of a dump is in flight
        fill_mem(1'b0);
        push_dump();
        tx0   = tx_total;
        sent0 = sent_total;
        send_byte(CMD_CONT_DEF);
        repeat (3) @(posedge clock);
        #1 ifc.haltIn = 1'b1;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 2000) begin
            @(negedge clock);
            #1;
            n++;
            if (ifc.txStart === 1'b1 && (tx_total - tx0) == 50) hit = 1'b1;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL reach_byte50 actual=%0d required=50", tx_total - tx0);
        end
        resetGral = 1'b0;
        #1;
        chk("rst_txstart_async", 32'(ifc.txStart), 32'(0));
        chk("rst_mode", 32'(mode_now()), 32'(M_IDLE));
        chk("rst_counter", 32'(ifc.sendCounter), 32'(0));
        chk("rst_pipe", 32'(ifc.pipeEnable), 32'(0));
        exp_q.delete();
        ifc.haltIn = 1'b0;
        repeat (10) @(posedge clock);
        #1 resetGral = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("rst_no_sentflag", 32'(sent_total - sent0), 32'(0));
        chk("rst_release_mode", 32'(mode_now()), 32'(M_IDLE));
        chk("rst_release_counter", 32'(ifc.sendCounter), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_sequencer.md
DEBUG_SEQUENCER -- requirements
Module: debug_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_WORDS, default 32, giving the number of 32-bit registers dumped per report.
REQ-002 The block SHALL have parameter CMD_CONT, default 8'h63, the command that starts continuous run.
REQ-003 The block SHALL have parameter CMD_STEP, default 8'h73, the command that enters step mode.
REQ-004 The block SHALL have parameter CMD_NEXT, default 8'h6E, the command that advances one step.
REQ-005 The block SHALL have parameter CMD_EXIT, default 8'h65, the command that leaves step mode.
REQ-006 clock  in  1  sole clock, rising edge.
REQ-007 resetGral  in  1  asynchronous, active-low reset.
REQ-008 rxData  in  8  received UART byte, valid when rxDone=1.
REQ-009 rxDone  in  1  one-cycle strobe, new byte on rxData.
REQ-010 haltIn  in  1  pipeline reached halt instruction (level).
REQ-011 regData  in  32  combinational read data for regAddr.
REQ-012 txDone  in  1  one-cycle strobe, UART TX finished the current byte.
REQ-013 pipeEnable  out  1  pipeline clock-enable.
REQ-014 regAddr  out  log2(NUM_WORDS) bits  register index being dumped.
REQ-015 txData  out  8  byte to transmit.
REQ-016 txStart  out  1  one-cycle TX start pulse.
REQ-017 ledIdle, ledStep, ledSend, ledCont  out  1 each  one-hot mode indicators.
REQ-018 sendCounter  out  8  bytes sent, mod 256, cumulative since reset.
REQ-019 sentFlag  out  1  one-cycle pulse at end of each complete dump.

Function
REQ-020 The FSM SHALL have states IDLE, CONT, STEP_WAIT, STEP_RUN, SEND_LOAD, SEND_WAIT, DONE.
REQ-021 IDLE: rxDone with CMD_CONT -> CONT; with CMD_STEP -> STEP_WAIT; any other byte ignored.
REQ-022 CONT: pipeEnable=1 every cycle; haltIn=1 -> SEND_LOAD with pipeEnable=0 in that same cycle; rxDone ignored.
REQ-023 STEP_WAIT: pipeEnable=0; CMD_NEXT -> STEP_RUN; CMD_EXIT -> IDLE; other bytes ignored.
REQ-024 STEP_RUN: pipeEnable=1 for exactly one cycle, then unconditionally -> SEND_LOAD.
REQ-025 SEND_LOAD: txData registered from regData byte selected by byteIdx (byte 3 first, MSB-first), txStart pulses high next cycle for exactly one cycle, -> SEND_WAIT.
REQ-026 SEND_WAIT: hold txData; on txDone, advance byteIdx 3->0 then wordIdx+1; sendCounter +1 (wraps 255->0); -> SEND_LOAD, or DONE after byte 0 of word NUM_WORDS-1.
REQ-027 regAddr SHALL equal wordIdx throughout SEND_LOAD/SEND_WAIT, and 0 elsewhere.
REQ-028 DONE: sentFlag=1 for one cycle; wordIdx/byteIdx cleared; -> IDLE if dump originated from CONT or haltIn=1, else -> STEP_WAIT.
REQ-029 rxDone in any SEND_*/DONE state SHALL be discarded, not queued.
REQ-030 rxDone and haltIn in same cycle in CONT: halt wins.
REQ-031 txDone outside SEND_WAIT SHALL be ignored.
REQ-032 Total bytes per dump SHALL be 4*NUM_WORDS (128 at default).
REQ-033 LEDs: ledIdle in IDLE; ledCont in CONT; ledStep in STEP_WAIT/STEP_RUN; ledSend in SEND_LOAD/SEND_WAIT/DONE; exactly one high.

Reset
REQ-034 On resetGral=0, state=IDLE, pipeEnable=0, txStart=0, txData=0, regAddr=0, sendCounter=0, sentFlag=0, ledIdle=1, other LEDs 0, indices 0, origin flag cleared.
REQ-035 Reset asserted mid-dump SHALL drop txStart immediately (asynchronously) and abandon the dump without a sentFlag pulse.

Structure
REQ-036 State encoding and the four command byte constants SHALL live in a shared debug package used by this block and the UART/datapath top level.
REQ-037 The byte-serialising send engine (SEND_LOAD/SEND_WAIT, indices, sendCounter) SHALL be one sub-module, debug_dump_engine, started by the FSM and returning a done pulse.

Verification
REQ-038 Reset, then rxDone with 8'h63, haltIn high after 10 cycles -> pipeEnable high exactly 10 cycles, 128 txStart pulses, sentFlag once, back to IDLE, sendCounter=128.
REQ-039 8'h73 then 8'h6E -> exactly one pipeEnable cycle, 128-byte dump, return to STEP_WAIT; 8'h65 -> IDLE.
REQ-040 regData=32'hDEADBEEF for word 0 -> first four txData values DE, AD, BE, EF in order.
REQ-041 Bytes 8'h6E and 8'h41 in IDLE, and 8'h63 during a dump -> no state change, no pipeEnable.
REQ-042 Three dumps back-to-back -> sendCounter wraps to 384 mod 256 = 128.
REQ-043 resetGral low during SEND_WAIT of byte 50 -> txStart=0, ledIdle=1, sendCounter=0, no sentFlag.
